// File: rtl/cm0ik_ahb_seq_master.sv
// ---------------------------------------------------------------------------
// cm0ik_ahb_seq_master
//
// Command-driven AHB-Lite initiator. It stands in for the processor during
// memory preload, fill and dump. One command produces cmd_count+1 SINGLE
// NONSEQ transfers to incrementing, size-aligned addresses. The transfers
// are either all reads or all pattern-fill writes. Transfers are fully
// pipelined: the address phase of beat n+1 overlaps the data phase of
// beat n. Wait states are honoured. The two-cycle ERROR response aborts
// the sequence.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only when idle)
//   cmd_write            1 = write sequence, 0 = read sequence
//   cmd_addr             start address (aligned down to the transfer size)
//   cmd_size             0 byte, 1 half, 2 word, 3 treated as word
//   cmd_count            number of beats minus one
//   cmd_wdata            write pattern base
//   cmd_incdata          1: beat n writes cmd_wdata+n, 0: constant cmd_wdata
//   HADDR..HWDATA        registered AHB-Lite master outputs
//   HRDATA/HREADY/HRESP  AHB-Lite slave response
//   rsp_valid            one-cycle pulse per completed beat
//   rsp_rdata            captured HRDATA (0 for writes)
//   rsp_err              beat ended with ERROR
//   rsp_last             final response of the sequence
//   busy                 a sequence is in progress
// ---------------------------------------------------------------------------
module cm0ik_ahb_seq_master #(
  parameter int         CNT_W     = 8,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [1:0]       cmd_size,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [31:0]      cmd_wdata,
  input  logic             cmd_incdata,

  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,

  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_last,
  output logic             busy
);

  // ADDR : an address phase is on the bus (a data phase may overlap it)
  // DRAIN: last address accepted, only the final data phase remains
  // ERR  : first ERROR cycle seen, waiting for the second (HREADY=1) cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DRAIN = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             htrans_nseq;   // HTRANS[1]; HTRANS is IDLE or NONSEQ only
  logic [CNT_W-1:0] addr_left;     // address phases still to issue after the current one
  logic [31:0]      wdata_cur;     // write data for the beat whose address is on the bus
  logic             seq_inc;
  logic             dp_valid;      // a beat is in its data phase
  logic             dp_last;       // that beat is the final one of the sequence

  logic [1:0]       size_eff;
  logic [31:0]      addr_aligned;
  logic [31:0]      addr_step;

  logic cmd_acc, addr_acc, beat_ok, beat_bad, err_first, err_done;

  assign HTRANS    = {htrans_nseq, 1'b0};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign size_eff  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
  assign addr_step = 32'd1 << HSIZE[1:0];

  always_comb begin
    case (size_eff)
      2'd0:    addr_aligned = cmd_addr;
      2'd1:    addr_aligned = {cmd_addr[31:1], 1'b0};
      default: addr_aligned = {cmd_addr[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the single-cycle event strobes that steer the datapath.
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the case leaves one unassigned and infers a latch.
    state_nxt = state;
    cmd_acc   = 1'b0;
    addr_acc  = 1'b0;
    beat_ok   = 1'b0;
    beat_bad  = 1'b0;
    err_first = 1'b0;
    err_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_acc   = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR, S_DRAIN: begin
        if (dp_valid && HRESP) begin
          if (HREADY) begin
            // ERROR without its first cycle: report it on this beat and abort.
            // The overlapping address phase is dropped with the sequence.
            beat_bad  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            // First ERROR cycle: HTRANS goes IDLE next cycle, which cancels
            // any pending address phase.
            err_first = 1'b1;
            state_nxt = S_ERR;
          end
        end else if (HREADY) begin
          beat_ok = dp_valid;
          if (state == S_ADDR) begin
            addr_acc = 1'b1;
            if (addr_left == '0) state_nxt = S_DRAIN;
          end else begin
            // In DRAIN the data phase is always the final beat.
            state_nxt = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (HREADY && HRESP) begin
          err_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_nseq <= 1'b0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= '0;
      HWDATA      <= '0;
      addr_left   <= '0;
      wdata_cur   <= '0;
      seq_inc     <= 1'b0;
      dp_valid    <= 1'b0;
      dp_last     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_last    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      rsp_valid <= beat_ok | beat_bad | err_done;
      rsp_err   <= beat_bad | err_done;
      rsp_last  <= beat_bad | err_done | (beat_ok & dp_last);
      if (beat_ok || beat_bad || err_done)
        rsp_rdata <= (beat_ok && !HWRITE) ? HRDATA : '0;

      if (cmd_acc) begin
        htrans_nseq <= 1'b1;
        HADDR       <= addr_aligned;
        HWRITE      <= cmd_write;
        HSIZE       <= {1'b0, size_eff};
        addr_left   <= cmd_count;
        wdata_cur   <= cmd_wdata;
        seq_inc     <= cmd_incdata;
        dp_valid    <= 1'b0;
        dp_last     <= 1'b0;
      end

      // Address accepted: this beat moves to its data phase and the next
      // beat's address (if any) is presented. Address and data hold
      // untouched through wait states because nothing here fires then.
      if (addr_acc) begin
        dp_valid  <= 1'b1;
        dp_last   <= (addr_left == '0);
        HWDATA    <= HWRITE ? wdata_cur : '0;
        wdata_cur <= wdata_cur + 32'(seq_inc);
        if (addr_left == '0) begin
          htrans_nseq <= 1'b0;
        end else begin
          HADDR     <= HADDR + addr_step;
          addr_left <= addr_left - CNT_W'(1);
        end
      end else if (beat_ok) begin
        dp_valid <= 1'b0;
      end

      if (beat_bad || err_first) begin
        htrans_nseq <= 1'b0;
        dp_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cm0ik_ahb_seq_master.sv
// ---------------------------------------------------------------------------
// tb_cm0ik_ahb_seq_master
//
// Self-checking bench. An AHB-Lite slave model inserts wait states and
// ERROR responses, and checks every accepted address phase and write data
// against an expected-beat queue. A response monitor pops an expected-
// response queue on every rsp_valid pulse. Both queues are filled from the
// command parameters alone: aligned start + n*size, pattern base + n, and
// truncation at the error beat.
// ---------------------------------------------------------------------------
module tb_cm0ik_ahb_seq_master;

  localparam int CNT_W = 8;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [31:0]      cmd_addr = '0;
  logic [1:0]       cmd_size = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [31:0]      cmd_wdata = '0;
  logic             cmd_incdata = 1'b0;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic             HMASTLOCK;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA = '0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             rsp_last;
  logic             busy;

  cm0ik_ahb_seq_master #(.CNT_W(CNT_W), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_count(cmd_count),
    .cmd_wdata(cmd_wdata), .cmd_incdata(cmd_incdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_last(rsp_last), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  size;
    bit          err;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          last;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int wait_mode = 0;      // 0: no waits, 1: random 0..3, 2: always 2
  int last_rsp_cyc = 0;

  always @(posedge HCLK) cyc++;

  function automatic logic [31:0] mem_val(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(string name, logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%08h (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- slave model ----------------
  beat_t       dp;
  bit          dp_act = 0;
  int          waits = 0;
  bit          err_st = 0;
  logic        prev_ready = 1'b1;
  bit          prev_err1 = 0;
  logic [1:0]  prev_trans = '0;
  logic [31:0] prev_addr = '0;
  logic        prev_write = 1'b0;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_act = 0; err_st = 0; HREADY = 1'b1; HRESP = 1'b0;
      prev_ready = 1'b1; prev_err1 = 0;
    end else begin
      if (!prev_ready && prev_trans == 2'b10 && !prev_err1) begin
        check("hold_haddr", HADDR, prev_addr);
        check("hold_htrans", HTRANS, 2'b10);
        check("hold_hwrite", HWRITE, prev_write);
      end
      prev_err1 = 0;
      HRDATA = $urandom;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp_act) begin
        if (err_st) begin
          check("err_htrans_idle", HTRANS, 2'b00);
          HRESP = 1'b1; dp_act = 0; err_st = 0;
        end else if (waits > 0) begin
          HREADY = 1'b0; waits--;
        end else if (dp.err) begin
          HREADY = 1'b0; HRESP = 1'b1; err_st = 1; prev_err1 = 1;
        end else begin
          if (dp.wr) check("hwdata", HWDATA, dp.wdata);
          else HRDATA = mem_val(dp.addr);
          dp_act = 0;
        end
      end
      if (HREADY && HTRANS == 2'b10) begin
        if (beat_q.size() == 0) begin
          fail("unexpected_addr_phase", HADDR);
        end else begin
          dp = beat_q.pop_front();
          check("haddr", HADDR, dp.addr);
          check("hwrite", HWRITE, dp.wr);
          check("hsize", HSIZE, dp.size);
          dp_act = 1;
          waits = (wait_mode == 0) ? 0 : (wait_mode == 2) ? 2 : int'($urandom_range(0, 3));
        end
      end
      prev_ready = HREADY; prev_trans = HTRANS; prev_addr = HADDR; prev_write = HWRITE;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail("unexpected_rsp", rsp_rdata);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_err", rsp_err, r.err);
        check("rsp_last", rsp_last, r.last);
        if (!r.err) check("rsp_rdata", rsp_rdata, r.rdata);
        if (r.last) begin
          check("cmd_ready_at_last", cmd_ready, 1'b1);
          check("busy_at_last", busy, 1'b0);
        end
        last_rsp_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_expect(bit wr, logic [31:0] addr, logic [1:0] size, int cnt,
                             logic [31:0] wd, bit inc, int err_beat);
    int sz;
    int lastb;
    logic [31:0] step;
    logic [31:0] a0;
    sz    = (size == 2'd3) ? 2 : int'(size);
    step  = 32'd1 << sz;
    a0    = addr & ~(step - 32'd1);
    lastb = (err_beat >= 0 && err_beat <= cnt) ? err_beat : cnt;
    for (int n = 0; n <= lastb; n++) begin
      beat_t b;
      rsp_t  r;
      b.addr  = a0 + step * n;
      b.wr    = wr;
      b.wdata = inc ? wd + n : wd;
      b.size  = 3'(sz);
      b.err   = (n == err_beat);
      beat_q.push_back(b);
      r.rdata = wr ? 32'd0 : mem_val(b.addr);
      r.err   = b.err;
      r.last  = (n == lastb);
      rsp_q.push_back(r);
    end
  endtask

  task automatic drive_cmd(bit wr, logic [31:0] addr, logic [1:0] size, int cnt,
                           logic [31:0] wd, bit inc);
    cmd_write = wr; cmd_addr = addr; cmd_size = size;
    cmd_count = CNT_W'(cnt); cmd_wdata = wd; cmd_incdata = inc;
    cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(bit wr, logic [31:0] addr, logic [1:0] size, int cnt,
                         logic [31:0] wd, bit inc, int err_beat, bit timing);
    int acc;
    bit done;
    push_expect(wr, addr, size, cnt, wd, inc, err_beat);
    @(negedge HCLK);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    drive_cmd(wr, addr, size, cnt, wd, inc);
    acc = cyc;
    @(posedge HCLK); #1;
    // A busy master must ignore a new command.
    drive_cmd(~wr, $urandom, 2'($urandom), int'($urandom_range(0, 255)), $urandom, 1'b0);
    @(negedge HCLK);
    if (timing) check("t1_htrans_nonseq", HTRANS, 2'b10);
    @(posedge HCLK);
    @(negedge HCLK);
    if (timing) check("t2_htrans_idle", HTRANS, 2'b00);
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    done = 0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge HCLK);
      if (rsp_q.size() == 0 && !busy) done = 1;
    end
    if (!done) fail("seq_timeout", rsp_q.size());
    check("addr_q_drained", beat_q.size(), 0);
    if (timing) check("t3_rsp_latency", last_rsp_cyc - acc, 3);
    beat_q.delete();
    rsp_q.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_htrans"}, HTRANS, 2'b00);
    check({tag, "_haddr"}, HADDR, 32'd0);
    check({tag, "_hwrite"}, HWRITE, 1'b0);
    check({tag, "_hsize"}, HSIZE, 3'd0);
    check({tag, "_hwdata"}, HWDATA, 32'd0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_last"}, rsp_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge HCLK);
    check_reset_outputs("rst");
    check("hburst", HBURST, 3'b000);
    check("hprot", HPROT, 4'b0011);
    check("hmastlock", HMASTLOCK, 1'b0);
    #2 HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Single word read, zero wait: NONSEQ at T+1 only, response at T+3.
    wait_mode = 0;
    run_cmd(1'b0, 32'h0000_0100, 2'd2, 0, 32'd0, 1'b0, -1, 1'b1);
    // Byte write, four beats, incrementing data from an unaligned byte address.
    run_cmd(1'b1, 32'h0000_0203, 2'd0, 3, 32'h10, 1'b1, -1, 1'b0);
    // Halfword read with two wait states on every beat; start address is aligned down.
    wait_mode = 2;
    run_cmd(1'b0, 32'h0000_0303, 2'd1, 1, 32'd0, 1'b0, -1, 1'b0);
    // Word read, ERROR on beat 1: beats 2-3 never reach the bus.
    wait_mode = 0;
    run_cmd(1'b0, 32'h0000_0400, 2'd2, 3, 32'd0, 1'b0, 1, 1'b0);
    // Word write wrapping past the top of the address space.
    run_cmd(1'b1, 32'hFFFF_FFF8, 2'd2, 2, 32'hA0, 1'b1, -1, 1'b0);
    // Size 3 behaves as word.
    run_cmd(1'b1, 32'h0000_0507, 2'd3, 1, 32'h55AA_0000, 1'b0, -1, 1'b0);
    // ERROR on the final beat, which is in its drain phase.
    wait_mode = 1;
    run_cmd(1'b0, 32'h0000_0600, 2'd2, 2, 32'd0, 1'b0, 2, 1'b0);

    // Asynchronous reset during beat 2 of an 8-beat read.
    begin
      bit seen;
      wait_mode = 0;
      push_expect(1'b0, 32'h0000_4000, 2'd2, 7, 32'd0, 1'b0, -1);
      @(negedge HCLK);
      drive_cmd(1'b0, 32'h0000_4000, 2'd2, 7, 32'd0, 1'b0);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge HCLK);
        if (beat_q.size() <= 5) seen = 1;
      end
      if (!seen) fail("rst_seq_start_timeout", beat_q.size());
      #2 HRESETn = 1'b0;
      #1 check_reset_outputs("async_rst");
      repeat (2) @(negedge HCLK);
      check_reset_outputs("held_rst");
      beat_q.delete();
      rsp_q.delete();
      #2 HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);
      run_cmd(1'b0, 32'h0000_0100, 2'd2, 0, 32'd0, 1'b0, -1, 1'b1);
    end

    // Full-length sequence: all-ones count gives 256 beats.
    run_cmd(1'b1, 32'h0000_8000, 2'd2, 255, 32'h0000_1000, 1'b1, -1, 1'b0);

    // Randomized commands with random wait states and occasional ERRORs.
    wait_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int cnt;
      int eb;
      cnt = int'($urandom_range(0, 15));
      eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt)) : -1;
      run_cmd(1'($urandom), $urandom, 2'($urandom), cnt, $urandom, 1'($urandom), eb, 1'b0);
    end

    repeat (3) @(negedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cm0ik_ahb_seq_master.md
Name: cm0ik_ahb_seq_master

Overview:
Command-driven AHB-Lite initiator for the Cortex-M0 integration kit. It issues sequences of single, incrementing-address reads or pattern-fill writes into AHB-Lite slaves, for example the SRAM bridge. Memory preload, fill and dump in integration tests use it as the bus master in place of the processor. Transfers are fully pipelined, wait states are honoured, and the AHB-Lite two-cycle ERROR response is handled.

Parameters:
CNT_W, 8, width of cmd_count; a sequence is cmd_count+1 beats, max 2^CNT_W.
HPROT_VAL, 4'b0011, constant HPROT driven on every transfer.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write sequence, 0=read sequence
cmd_addr  in  32  start address; low bits are masked to size alignment
cmd_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
cmd_count  in  CNT_W  beats minus one
cmd_wdata  in  32  write pattern base
cmd_incdata  in  1  1: beat n data = cmd_wdata+n; 0: constant cmd_wdata
HADDR  out  32  AHB address
HTRANS  out  2  IDLE(00) or NONSEQ(10) only
HWRITE  out  1  transfer direction
HSIZE  out  3  {1'b0,size}
HBURST  out  3  always 3'b000 (SINGLE)
HPROT  out  4  HPROT_VAL
HMASTLOCK  out  1  always 0
HWDATA  out  32  write data in data phase
HRDATA  in  32  read data
HREADY  in  1  transfer done / wait
HRESP  in  1  error response
rsp_valid  out  1  one-cycle pulse per completed beat; no backpressure
rsp_rdata  out  32  captured HRDATA; 0 for writes
rsp_err  out  1  beat ended with ERROR
rsp_last  out  1  final response of the sequence
busy  out  1  state != IDLE

Behaviour:
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_last=0, busy=0, cmd_ready=1. All AHB outputs are registered.
- States: IDLE, ADDR, DRAIN, ERR.
- Address phase timing:
  - Command accepted in cycle T. At T+1, HTRANS=NONSEQ, HADDR=aligned cmd_addr; the FSM moves to ADDR.
  - An address phase is accepted on a rising edge with HREADY=1. At that edge, the next beat's address is presented with HADDR += (1<<size), mod 2^32; 0xFFFFFFFC+4 wraps to 0.
  - When the last beat's address is accepted: HTRANS<=IDLE, FSM goes to DRAIN.
  - While HREADY=0, HADDR, HTRANS, HWRITE, HSIZE and HWDATA hold.
- Data phase:
  - HWDATA for beat n is driven in the cycle after beat n's address acceptance. It holds through wait states.
  - A beat completes on an edge with HREADY=1 in its data phase. The next cycle has rsp_valid=1 and rsp_rdata=HRDATA (reads).
- Sequence end:
  - On the final beat's completion, FSM returns to IDLE.
  - rsp_last=1 with that rsp_valid.
  - cmd_ready=1 in the same cycle as that rsp_valid.
- Single read with zero wait states:
  - T: accept.
  - T+1: address phase.
  - T+2: data phase.
  - T+3: rsp_valid, cmd_ready.
- Error handling:
  - HRESP=1 with HREADY=0 in a data phase is the first error cycle. In the next cycle, HTRANS is IDLE; any pending address phase is cancelled, which AHB-Lite permits. FSM goes to ERR.
  - ERR waits for HRESP=1 & HREADY=1. The following cycle has rsp_valid=1, rsp_err=1, rsp_last=1; FSM returns to IDLE.
  - No further beats are issued and no response is produced for cancelled beats.
  - HRESP=1 with HREADY=1 without a preceding first cycle is a protocol violation. It is reported as an error on that beat: rsp_err=1, same abort.
- cmd_valid outside IDLE is ignored; the command must be held until cmd_ready.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately and the sequence is lost. The slave sees HTRANS=IDLE.
- Beat counter is CNT_W bits and counts down to 0. cmd_count=0 gives one beat; the all-ones value gives 2^CNT_W beats.

Test Plan:
- Read, word, count=0, addr 0x100, zero wait, HRDATA=0xCAFEF00D -> HTRANS=10 at T+1 only; rsp_valid at T+3 with rdata 0xCAFEF00D, last=1, err=0.
- Write, byte, count=3, addr 0x203, wdata=0x10, incdata=1 -> HADDR 0x203,0x204,0x205,0x206 on back-to-back cycles; HWDATA 0x10,0x11,0x12,0x13 each one cycle later; HSIZE=000; 4 rsp pulses, last on 4th.
- Read, half, count=1, slave inserts HREADY=0 for 2 cycles on beat 0 -> address/HWRITE/HTRANS held stable; beat 1 address not accepted until HREADY=1; responses 2 cycles delayed.
- Read, word, count=3, ERROR on beat 1 -> HTRANS=IDLE in cycle after first error cycle; rsp for beat 0 ok; rsp for beat 1 with err=1, last=1; no access to beats 2–3; cmd_ready=1 after.
- Word write starting at 0xFFFFFFF8, count=2 -> HADDR 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- HRESETn low during beat 2 of 8 -> all outputs at reset values asynchronously; after release, a new count=0 read completes normally.
